// File: rtl/riscv_pkg.sv
// Shared core definitions: load/store size encodings and LSU state type.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Misaligned, unencodable, or unsigned-store requests are rejected.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] size,
                                       input logic [1:0] addr_lo);
    logic err;
    case (size)
      LDST_B:  err = 1'b0;
      LDST_BU: err = we;
      LDST_H:  err = addr_lo[0];
      LDST_HU: err = we | addr_lo[0];
      LDST_W:  err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/riscv_lsu_load_fmt.sv
// Load-data formatter: selects the addressed byte/half lane and extends it.
module lsu_load_fmt
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_i)
      2'd0:    byte_lane = mem_rd_i[7:0];
      2'd1:    byte_lane = mem_rd_i[15:8];
      2'd2:    byte_lane = mem_rd_i[23:16];
      default: byte_lane = mem_rd_i[31:24];
    endcase
    half_lane = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    case (size_i)
      LDST_B:  data_o = {{24{byte_lane[7]}}, byte_lane};
      LDST_BU: data_o = {24'h0, byte_lane};
      LDST_H:  data_o = {{16{half_lane[15]}}, half_lane};
      LDST_HU: data_o = {16'h0, half_lane};
      LDST_W:  data_o = mem_rd_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core byte/half/word accesses into aligned word
// transactions with byte enables, stalling the core until memory responds.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] fmt_rd;
  logic [3:0]  be;
  logic [31:0] st_data;

  lsu_load_fmt u_load_fmt (
    .mem_rd_i (mem_rd_i),
    .size_i   (size_q),
    .addr_i   (addr_q[1:0]),
    .data_o   (fmt_rd)
  );

  always_comb begin
    case (size_q)
      LDST_B, LDST_BU: be = 4'b0001 << addr_q[1:0];
      LDST_H, LDST_HU: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
    case (size_q)
      LDST_B:  st_data = {4{wd_q[7:0]}};
      LDST_H:  st_data = {2{wd_q[15:0]}};
      default: st_data = wd_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;

    // Outputs are forced low for the whole reset cycle, not just after it.
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            if (lsu_req_err(core_we_i, core_size_i, core_addr_i[1:0])) begin
              core_err_o = 1'b1;
            end else begin
              we_d         = core_we_i;
              size_d       = core_size_i;
              addr_d       = core_addr_i;
              wd_d         = core_wd_i;
              core_stall_o = 1'b1;
              state_d      = BUSY;
            end
          end
        end
        BUSY: begin
          mem_req_o  = 1'b1;
          mem_we_o   = we_q;
          mem_be_o   = be;
          mem_addr_o = {addr_q[31:2], 2'b00};
          mem_wd_o   = we_q ? st_data : '0;
          if (mem_ready_i) begin
            state_d = IDLE;
            if (!we_q) core_rd_o = fmt_rd;
          end else begin
            core_stall_o = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: stalls, lanes, extension, errors, wait states, reset.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, core_req, core_we, mem_ready;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, mem_rd;
  logic [31:0] core_rd, mem_addr, mem_wd;
  logic        core_stall, core_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [69:0] mem_bus, exp_m;
  logic [33:0] core_bus, exp_c;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  assign mem_bus  = {mem_req, mem_we, mem_be, mem_addr, mem_wd};
  assign core_bus = {core_stall, core_err, core_rd};

  // Apply one cycle of inputs on the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic req, input logic we,
                       input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy,
                       input logic [31:0] rd);
    @(negedge clk);
    rst = r; core_req = req; core_we = we; core_size = sz;
    core_addr = a; core_wd = wd; mem_ready = rdy; mem_rd = rd;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 0, LDST_W, 32'h100, 32'h5555_5555, 1, 32'hFFFF_FFFF);
    drive(1, 1, 1, LDST_B, 32'h101, 32'h5555_5555, 1, 32'hFFFF_FFFF);
    checks++;
    if ({mem_bus, core_bus} !== 104'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {mem_bus, core_bus});
    end
  endtask

  task automatic test_lw;
    drive(0, 1, 0, LDST_W, 32'h100, 32'h5555_5555, 0, 32'h0);
    exp_c = {1'b1, 1'b0, 32'h0}; checks++;
    if (core_bus !== exp_c || mem_req !== 1'b0) begin
      errors++; $display("FAIL lw_req got %h req=%b exp %h req=0", core_bus, mem_req, exp_c);
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
    exp_m = {1'b1, 1'b0, 4'b1111, 32'h100, 32'h0}; checks++;
    if (mem_bus !== exp_m) begin
      errors++; $display("FAIL lw_mem got %h exp %h", mem_bus, exp_m);
    end
    exp_c = {1'b0, 1'b0, 32'hDEAD_BEEF}; checks++;
    if (core_bus !== exp_c) begin
      errors++; $display("FAIL lw_rsp got %h exp %h", core_bus, exp_c);
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
    checks++;
    if ({mem_bus, core_bus} !== 104'h0) begin
      errors++; $display("FAIL lw_idle got %h exp 0", {mem_bus, core_bus});
    end
  endtask

  task automatic test_load_fmt;
    logic [2:0]  sz   [4] = '{LDST_B, LDST_BU, LDST_H, LDST_HU};
    logic [31:0] ad   [4] = '{32'h103, 32'h103, 32'h106, 32'h104};
    logic [31:0] rdv  [4] = '{32'h80FF_0011, 32'h80FF_0011, 32'h8001_7FFF, 32'hFFFF_8000};
    logic [3:0]  ebe  [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    logic [31:0] erd  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, sz[i], ad[i], 32'h0, 0, 32'h0);
      drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, rdv[i]);
      exp_m = {1'b1, 1'b0, ebe[i], ad[i] & 32'hFFFF_FFFC, 32'h0}; checks++;
      if (mem_bus !== exp_m) begin
        errors++; $display("FAIL fmt%0d_mem got %h exp %h", i, mem_bus, exp_m);
      end
      exp_c = {1'b0, 1'b0, erd[i]}; checks++;
      if (core_bus !== exp_c) begin
        errors++; $display("FAIL fmt%0d_rd got %h exp %h", i, core_bus, exp_c);
      end
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_store_half;
    drive(0, 1, 1, LDST_H, 32'h202, 32'h1234_ABCD, 0, 32'h0);
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'hFFFF_FFFF);
    exp_m = {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCD_ABCD}; checks++;
    if (mem_bus !== exp_m) begin
      errors++; $display("FAIL sh_mem got %h exp %h", mem_bus, exp_m);
    end
    checks++;
    if (core_bus !== 34'h0) begin
      errors++; $display("FAIL sh_core got %h exp 0", core_bus);
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_back_to_back;
    int stalls = 0;
    drive(0, 1, 0, LDST_W, 32'h10C, 32'h0, 0, 32'h0);
    stalls += int'(core_stall);
    for (int i = 0; i < 3; i++) begin
      // A new core request during BUSY must not disturb the captured access.
      drive(0, 1, 1, LDST_B, 32'h400 + i, 32'hFFFF_FFFF, 0, 32'h0);
      stalls += int'(core_stall);
      exp_m = {1'b1, 1'b0, 4'b1111, 32'h10C, 32'h0}; checks++;
      if (mem_bus !== exp_m || core_err !== 1'b0) begin
        errors++; $display("FAIL wait%0d_mem got %h err=%b exp %h err=0", i, mem_bus, core_err, exp_m);
      end
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
    stalls += int'(core_stall);
    exp_c = {1'b0, 1'b0, 32'hCAFE_F00D}; checks++;
    if (core_bus !== exp_c) begin
      errors++; $display("FAIL wait_rsp got %h exp %h", core_bus, exp_c);
    end
    checks++;
    if (stalls !== 4) begin
      errors++; $display("FAIL wait_stall_cycles got %0d exp 4", stalls);
    end
    drive(0, 1, 1, LDST_B, 32'h111, 32'h0000_00A5, 0, 32'h0);
    checks++;
    if ({core_stall, core_err, mem_req} !== 3'b100) begin
      errors++; $display("FAIL b2b_accept got %b exp 100", {core_stall, core_err, mem_req});
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'h0);
    exp_m = {1'b1, 1'b1, 4'b0010, 32'h110, 32'hA5A5_A5A5}; checks++;
    if (mem_bus !== exp_m || core_bus !== 34'h0) begin
      errors++; $display("FAIL b2b_sb got %h/%h exp %h/0", mem_bus, core_bus, exp_m);
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_errors;
    logic        wev [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  sz  [4] = '{LDST_W, LDST_BU, LDST_H, 3'd3};
    logic [31:0] ad  [4] = '{32'h102, 32'h100, 32'h101, 32'h100};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, wev[i], sz[i], ad[i], 32'h77, 1, 32'h1);
      checks++;
      if ({mem_bus, core_bus} !== {70'h0, 2'b01, 32'h0}) begin
        errors++; $display("FAIL err%0d got %h exp err only", i, {mem_bus, core_bus});
      end
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'h1);
    checks++;
    if ({mem_bus, core_bus} !== 104'h0) begin
      errors++; $display("FAIL err_stays_idle got %h exp 0", {mem_bus, core_bus});
    end
  endtask

  task automatic test_reset_busy;
    drive(0, 1, 0, LDST_W, 32'h300, 32'h0, 0, 32'h0);
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'h0);
    drive(1, 0, 0, LDST_W, 32'h0, 32'h0, 0, 32'h0);
    checks++;
    if ({mem_bus, core_bus} !== 104'h0) begin
      errors++; $display("FAIL rst_busy_during got %h exp 0", {mem_bus, core_bus});
    end
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'h1111_1111);
    checks++;
    if ({mem_bus, core_bus} !== 104'h0) begin
      errors++; $display("FAIL rst_busy_after got %h exp 0", {mem_bus, core_bus});
    end
    drive(0, 1, 0, LDST_W, 32'h304, 32'h0, 0, 32'h0);
    drive(0, 0, 0, LDST_W, 32'h0, 32'h0, 1, 32'h1234_5678);
    exp_m = {1'b1, 1'b0, 4'b1111, 32'h304, 32'h0};
    exp_c = {1'b0, 1'b0, 32'h1234_5678}; checks++;
    if (mem_bus !== exp_m || core_bus !== exp_c) begin
      errors++; $display("FAIL rst_then_lw got %h/%h exp %h/%h", mem_bus, core_bus, exp_m, exp_c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = LDST_W;
    core_addr = '0; core_wd = '0; mem_rd = '0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_load_fmt();
    test_store_half();
    test_back_to_back();
    test_errors();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
